tmds_channel_decoder: RTL and testbench

//  Receive-side counterpart of the DVI/HDMI TMDS encoder: one instance per data channel (d0/d1/d2).

---
 rtl/tmds_channel_decoder.sv | 74 +++++++
 tb/tb_tmds_channel_decoder.sv | 137 +++++++++++++
 2 files changed

// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: TMDS receive channel with bitslip word alignment and 10b->8b/control decode
module tmds_channel_decoder #(
  parameter int TOKEN_RUN     = 8,
  parameter int SEARCH_WINDOW = 4096,
  parameter int SLIP_SETTLE   = 16,
  parameter int LOSS_WINDOW   = 8192
) (
  input  logic       pixel_clock,
  input  logic       reset,
  input  logic [9:0] tmds_word,
  output logic       bitslip,
  output logic       aligned,
  output logic [3:0] slip_count,
  output logic       de,
  output logic       c0,
  output logic       c1,
  output logic [7:0] data
);
  typedef enum logic [1:0] {SEARCH, SETTLE, LOCKED} state_t;
  state_t      state_q, state_d;
  logic [7:0]  run_q;
  logic [15:0] win_q;
  logic        bitslip_q, aligned_q, de_q;
  logic [3:0]  slip_count_q;
  logic [1:0]  c_q, tok_c;
  logic [7:0]  data_q, d, dec;
  logic        is_tok, run_ok, slip;
  always_comb begin
    is_tok = tmds_word == 10'h354 || tmds_word == 10'h0AB || tmds_word == 10'h154 || tmds_word == 10'h2AB;
    tok_c  = tmds_word == 10'h0AB ? 2'b01 : tmds_word == 10'h154 ? 2'b10 : tmds_word == 10'h2AB ? 2'b11 : 2'b00;
    d      = tmds_word[9] ? ~tmds_word[7:0] : tmds_word[7:0];
    dec    = {d[7:1] ^ d[6:0] ^ {7{~tmds_word[8]}}, d[0]};
    run_ok = state_q != SETTLE && is_tok && run_q == 8'(TOKEN_RUN - 1);
    slip   = state_q == SEARCH && !run_ok && win_q == 16'(SEARCH_WINDOW - 1);
    state_d = state_q;
    if (state_q == SEARCH)
      state_d = run_ok ? LOCKED : slip ? SETTLE : SEARCH;
    else if (state_q == SETTLE)
      state_d = win_q == 16'(SLIP_SETTLE - 1) ? SEARCH : SETTLE;
    else
      state_d = !run_ok && win_q == 16'(LOSS_WINDOW - 1) ? SEARCH : LOCKED;
  end
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      state_q      <= SEARCH;
      run_q        <= '0;
      win_q        <= '0;
      bitslip_q    <= 1'b0;
      aligned_q    <= 1'b0;
      slip_count_q <= '0;
      de_q         <= 1'b0;
      c_q          <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      run_q        <= (state_q == SETTLE || slip || !is_tok) ? 8'd0 : run_q == 8'd255 ? run_q : run_q + 8'd1;
      win_q        <= (state_d != state_q || run_ok) ? 16'd0 : win_q + 16'd1;
      bitslip_q    <= slip;
      slip_count_q <= slip_count_q + {3'b000, slip};
      aligned_q    <= state_d == LOCKED;
      c_q          <= is_tok ? tok_c : c_q;
      // gate on the next state so de/data drop in step with aligned
      de_q         <= state_d == LOCKED && !is_tok;
      data_q       <= (state_d == LOCKED && !is_tok) ? dec : 8'd0;
    end
  end
  assign bitslip    = bitslip_q;
  assign aligned    = aligned_q;
  assign slip_count = slip_count_q;
  assign de         = de_q;
  assign c0         = c_q[0];
  assign c1         = c_q[1];
  assign data       = data_q;
endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb_tmds_channel_decoder: directed bench for the TMDS channel decoder with a bitslipping deserialiser model
module tb_tmds_channel_decoder;
  localparam int TR = 8, SW = 2400, SS = 16, LW = 3000, LINE = 2200;
  logic       clk = 1'b0, rst = 1'b1;
  logic [9:0] tmds_word = '0;
  logic       bitslip, aligned, de, c0, c1;
  logic [3:0] slip_count;
  logic [7:0] data;
  logic [16:0] obs;
  logic [9:0] line [LINE];
  int checks = 0, failures = 0;
  tmds_channel_decoder #(.TOKEN_RUN(TR), .SEARCH_WINDOW(SW), .SLIP_SETTLE(SS), .LOSS_WINDOW(LW)) dut (
    .pixel_clock(clk), .reset(rst), .tmds_word(tmds_word), .bitslip(bitslip), .aligned(aligned),
    .slip_count(slip_count), .de(de), .c0(c0), .c1(c1), .data(data));
  always #5 clk = ~clk;
  assign obs = {bitslip, aligned, slip_count, de, c1, c0, data};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic [9:0] w);
    tmds_word = w;
    @(posedge clk);
    #1;
  endtask
  function automatic bit is_token(input logic [9:0] w);
    return w == 10'h354 || w == 10'h0AB || w == 10'h154 || w == 10'h2AB;
  endfunction
  function automatic logic [9:0] wire_word(input int k, input int s);
    logic [9:0] w;
    int p;
    for (int b = 0; b < 10; b++) begin
      p = 10 * k + s + b;
      w[b] = line[(p / 10) % LINE][p % 10];
    end
    return w;
  endfunction
  task automatic wait_slip(input string tag);
    int n = 0;
    while (!bitslip && n < SW + SS + 100) begin
      step(10'h100);
      n++;
    end
    if (!bitslip) chk(tag, 0, 1);
  endtask
  initial begin
    int k, s, pulses, last, cyc;
    bit gap_ok;
    logic [9:0] w;
    for (int i = 0; i < LINE; i++) begin
      w = 10'($urandom);
      while (is_token(w)) w = 10'($urandom);
      line[i] = i < 280 ? 10'h354 : w;
    end
    // reset with random words: everything zero, no bitslip
    for (int i = 0; i < 5; i++) begin
      step(10'($urandom));
      chk("reset_hold", obs, 0);
    end
    rst = 1'b0;
    // stream 3 bits off; model slips on each pulse until aligned
    k = 0; s = 7; pulses = 0; last = -1000; cyc = 0; gap_ok = 1;
    while (!aligned && cyc < 12000) begin
      step(wire_word(k, s));
      k++; cyc++;
      if (bitslip) begin
        pulses++;
        if (cyc - last <= SS) gap_ok = 0;
        last = cyc;
        s++;
        if (s == 10) begin s = 0; k++; end
      end
    end
    chk("align_pulses", pulses, 3);
    chk("align_gap", gap_ok, 1);
    chk("align_locked", aligned, 1);
    chk("align_slip_count", slip_count, 3);
    // locked decode vectors
    step(10'h354); chk("dec_354", {de, c1, c0, data}, {1'b0, 2'b00, 8'h00});
    step(10'h2AB); chk("dec_2ab", {de, c1, c0, data}, {1'b0, 2'b11, 8'h00});
    step(10'h100); chk("dec_100", {de, c1, c0, data}, {1'b1, 2'b11, 8'h00});
    step(10'h3FF); chk("dec_3ff", {de, c1, c0, data}, {1'b1, 2'b11, 8'h00});
    step(10'h0FF); chk("dec_0ff", {de, c1, c0, data}, {1'b1, 2'b11, 8'hFF});
    step(10'h1AA); chk("dec_1aa", {de, c1, c0, data}, {1'b1, 2'b11, 8'hFE});
    step(10'h055); chk("dec_055", {de, c1, c0, data}, {1'b1, 2'b11, 8'h01});
    // fresh run then only data: lock lost after LW data cycles
    step(10'h100);
    for (int i = 0; i < TR; i++) step(10'h354);
    pulses = 0;
    for (int i = 1; i <= LW; i++) begin
      step(10'h0FF);
      if (bitslip) pulses++;
      if (i == LW - 1) chk("loss_before", {aligned, de, data}, {1'b1, 1'b1, 8'hFF});
    end
    chk("loss_after", {aligned, de, data}, 0);
    chk("loss_no_slip", pulses, 0);
    // short runs do not lock; a full run does
    for (int i = 0; i < TR - 1; i++) step(10'h154);
    step(10'h0FF);
    chk("short_forced", {aligned, de, c1, c0, data}, {1'b0, 1'b0, 2'b10, 8'h00});
    for (int i = 0; i < TR - 1; i++) step(10'h154);
    chk("short_nolock", aligned, 0);
    step(10'h0FF);
    for (int i = 0; i < TR - 1; i++) step(10'h154);
    chk("run_minus1", aligned, 0);
    step(10'h154);
    chk("run_lock", aligned, 1);
    step(10'h055);
    chk("run_decode", {de, c1, c0, data}, {1'b1, 2'b10, 8'h01});
    // reset on the bitslip cycle
    rst = 1'b1; step(10'h100); rst = 1'b0;
    chk("rst_clean", obs, 0);
    step(10'h154);
    wait_slip("slip1_timeout");
    chk("slip1_state", {bitslip, slip_count, c1, c0}, {1'b1, 4'd1, 2'b10});
    rst = 1'b1; step(10'h100); rst = 1'b0;
    chk("rst_on_slip", obs, 0);
    // reset during SETTLE
    wait_slip("slip2_timeout");
    for (int i = 0; i < 5; i++) step(10'h100);
    chk("settle_state", {bitslip, aligned, slip_count}, {1'b0, 1'b0, 4'd1});
    rst = 1'b1; step(10'h100); rst = 1'b0;
    chk("rst_in_settle", obs, 0);
    // 16 slips wrap the counter
    for (int i = 1; i <= 16; i++) begin
      wait_slip("wrap_timeout");
      step(10'h100);
      if (i == 15) chk("wrap_15", slip_count, 15);
    end
    chk("wrap_0", slip_count, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
